clock_divider_bank: RTL and testbench
=====================================

// Module: clock_divider_bank
// PURPOSE
//  N-channel programmable clock divider. Successor to the fixed single-divisor divider.
//  Runs on one edge only, with a runtime period, duty cycle and phase per channel.
//  Divisor changes never glitch the output. A common sync pulse realigns the channels.
//  Drives slow peripheral clocks and strobe ticks, e.g. LED scan, UART baud, sampling.
// PARAMETERS
//  N_CH        4     number of independent output channels (1..16)
//  W           16    width of the period, high and phase fields
//  DEF_PERIOD  2     period loaded at reset for every channel (>=2)
// PORTS
//  clk_in      in   1            sole clock; all logic on posedge only
//  rst         in   1            reset, asynchronous, active-high
//  cfg_we      in   1            write strobe for one channel's config
//  cfg_ch      in   clog2(N_CH)  channel written; values >=N_CH are ignored
//  cfg_period  in   W            output period in clk_in cycles
//  cfg_high    in   W            cycles clk_out is high per period
//  cfg_phase   in   W            counter start value on enable or sync
//  en          in   N_CH         per-channel run enable
//  sync        in   1            one-cycle pulse; restarts all enabled channels at their phase
//  clk_out     out  N_CH         divided clocks, registered
//  tick        out  N_CH         one-cycle pulse on each clk_out rising edge
//  cfg_pending out  N_CH         1 = shadow config written but not yet active
// BEHAVIOUR
//  Reset (async, rst=1): cnt=0, period=DEF_PERIOD, high=DEF_PERIOD/2, phase=0.
//    Shadow config equals the active config. clk_out=0, tick=0, cfg_pending=0.
//  Per-channel counter cnt runs 0..P-1 and wraps to 0. P is the active period.
//  clk_out and tick are registered from next-state values, so they align exactly with cnt:
//    clk_out = (cnt < H); tick = en & (cnt==0) & (previous cnt != 0 or just started).
//  Clamps applied when config is loaded into the active set:
//    P = max(cfg_period, 2).
//    H = min(max(cfg_high, 1), P-1).
//    phase = (cfg_phase < P) ? cfg_phase : 0.
//    Outputs are therefore always toggling with a duty cycle strictly between 0 and 100%.
//  cfg_we latches the period, high and phase fields into the cfg_ch shadow.
//    cfg_pending[ch] sets on the next cycle.
//  Shadow-to-active load happens only at a period boundary, so there is no runt pulse:
//    the cycle where cnt==P-1 and the counter wraps;
//    any cycle with en[ch]=0 (idle channels load immediately);
//    a sync cycle.
//    cfg_pending clears on load.
//  Write in the same cycle as the boundary: the new value is used for the period that starts next cycle.
//  en[ch]=0: cnt held at active phase, clk_out=0, tick=0.
//  en rising: the first enabled cycle has cnt=phase.
//    clk_out = (phase < H); tick=1 only if phase==0.
//  en falling mid-period: clk_out drops to 0 next cycle. A truncated high pulse is allowed here.
//  sync: every enabled channel loads pending shadow then sets cnt=phase on the next cycle.
//    sync overrides a simultaneous wrap. Disabled channels ignore sync.
//  Latency: config write -> effect <= P_old cycles. en -> clk_out 1 cycle.
//  Counter width W. No overflow possible, since cnt < P <= 2^W-1.
// STRUCTURE
//  clkdiv_pkg: MIN_PERIOD=2, cfg record {period, high, phase}, clamp function.
//  Sub-module clock_divider_channel: one counter, shadow and active config, output regs.
//    Instantiated N_CH times by generate.
//  The top level holds only the cfg_ch decode and the sync fan-out.
// TESTING
//  1 Reset default: DEF_PERIOD=2, en=1 -> clk_out toggles every cycle.
//    tick on every second cycle; all outputs 0 while rst=1.
//  2 ch0 period=5 high=2 phase=0 -> clk_out pattern 11000 repeating, tick every 5 cycles.
//    cfg_pending clears after load.
//  3 Period 10->3 written mid-period at cnt=4 -> current period completes 10 cycles.
//    Then 3-cycle periods follow; no pulse shorter than the programmed high.
//  4 Clamp check: period=0 high=0 -> behaves as P=2 H=1.
//    high=9 with P=4 -> H=3. phase=7 with P=4 -> phase=0.
//  5 ch0 phase=0, ch1 phase=2, both P=4; assert sync -> next cycle cnt0=0, cnt1=2.
//    tick0 that cycle, tick1 two cycles later; repeat sync on a wrap cycle.
//  6 Assert rst mid-period with clk_out=1 -> clk_out=0 immediately.
//    Released: shadow writes were discarded and DEF_PERIOD resumes.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and config clamp helpers for the clock divider bank
package clkdiv_pkg;

    localparam int MIN_PERIOD = 2;

    // Clamps keep every active config toggling: 2 <= P, 1 <= H <= P-1, phase < P.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
    endfunction

    function automatic logic [31:0] clamp_high(input logic [31:0] h, input logic [31:0] p);
        logic [31:0] hh;
        hh = (h == 32'd0) ? 32'd1 : h;
        return (hh > p - 32'd1) ? p - 32'd1 : hh;
    endfunction

    function automatic logic [31:0] clamp_phase(input logic [31:0] ph, input logic [31:0] p);
        return (ph < p) ? ph : 32'd0;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// rtl/clock_divider_channel.sv - one divider channel: counter, shadow/active config, output regs
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int W          = 16,
    parameter int DEF_PERIOD = 2
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    input  logic [W-1:0] cfg_phase,
    input  logic         en,
    input  logic         sync,
    output logic         clk_out,
    output logic         tick,
    output logic         cfg_pending
);

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic [W-1:0] phase;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{period: W'(DEF_PERIOD), high: W'(DEF_PERIOD / 2), phase: '0};

    cfg_t         act_q, act_d, sh_q, sh_d, clp;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pending_q, pending_d;
    logic         en_q;
    logic         clk_q, clk_d, tick_q, tick_d;
    logic         wrap, load;

    always_comb begin
        sh_d = sh_q;
        if (cfg_we) begin
            sh_d = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
        end

        clp.period = W'(clamp_period(32'(sh_d.period)));
        clp.high   = W'(clamp_high(32'(sh_d.high), 32'(clp.period)));
        clp.phase  = W'(clamp_phase(32'(sh_d.phase), 32'(clp.period)));

        // Loads only at period boundaries (wrap, idle, sync) so no runt pulse escapes.
        wrap  = en && en_q && (cnt_q == act_q.period - W'(1));
        load  = !en || sync || wrap;
        act_d = load ? clp : act_q;

        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b0;
        end else if (cfg_we) begin
            pending_d = 1'b1;
        end

        if (!en || !en_q || sync) begin
            cnt_d = act_d.phase;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end

        clk_d  = en && (cnt_d < act_d.high);
        tick_d = en && (cnt_d == '0);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            act_q     <= DEF_CFG;
            sh_q      <= DEF_CFG;
            pending_q <= 1'b0;
            en_q      <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            sh_q      <= sh_d;
            pending_q <= pending_d;
            en_q      <= en;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out     = clk_q;
    assign tick        = tick_q;
    assign cfg_pending = pending_q;

endmodule

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - N-channel programmable clock divider with common sync realignment
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W          = 16,
    parameter int DEF_PERIOD = 2,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [W-1:0]    cfg_period,
    input  logic [W-1:0]    cfg_high,
    input  logic [W-1:0]    cfg_phase,
    input  logic [N_CH-1:0] en,
    input  logic            sync,
    output logic [N_CH-1:0] clk_out,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] cfg_pending
);

    // Channel indices at or above N_CH never match, so such writes are dropped.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        clock_divider_channel #(
            .W          (W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk_in      (clk_in),
            .rst         (rst),
            .cfg_we      (ch_we),
            .cfg_period  (cfg_period),
            .cfg_high    (cfg_high),
            .cfg_phase   (cfg_phase),
            .en          (en[i]),
            .sync        (sync),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - directed scoreboard bench for clock_divider_bank
module tb_clock_divider_bank;

    localparam int N_CH = 4;
    localparam int W    = 16;

    logic            clk_in = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic [W-1:0]    cfg_period, cfg_high, cfg_phase;
    logic [N_CH-1:0] en;
    logic            sync;
    logic [N_CH-1:0] clk_out, tick, cfg_pending;

    always #5 clk_in = ~clk_in;

    clock_divider_bank #(.N_CH(N_CH), .W(W), .DEF_PERIOD(2)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_phase   (cfg_phase),
        .en          (en),
        .sync        (sync),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    typedef struct {
        string      tag;
        logic [3:0] clk;
        logic [3:0] tck;
        logic [3:0] pend;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int         m_cnt[4];
    int         m_p[4];
    int         m_h[4];
    logic [3:0] m_en;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic step(input string tag, input logic [3:0] eclk, input logic [3:0] etck,
                        input logic [3:0] epend);
        exp_t e;
        e.tag = tag; e.clk = eclk; e.tck = etck; e.pend = epend;
        sb.push_back(e);
        @(posedge clk_in);
        @(negedge clk_in);
        e = sb.pop_front();
        chk({e.tag, ".clk_out"}, clk_out, e.clk);
        chk({e.tag, ".tick"}, tick, e.tck);
        chk({e.tag, ".pending"}, cfg_pending, e.pend);
    endtask

    task automatic run(input string tag, input int n, input logic [3:0] epend);
        for (int c = 0; c < n; c++) begin
            logic [3:0] ec, et;
            ec = '0;
            et = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_en[i]) begin
                    ec[i] = (m_cnt[i] < m_h[i]);
                    et[i] = (m_cnt[i] == 0);
                end
            end
            step(tag, ec, et, epend);
            for (int i = 0; i < 4; i++) begin
                if (m_en[i]) m_cnt[i] = (m_cnt[i] + 1) % m_p[i];
            end
        end
    endtask

    task automatic write(input int ch, input int p, input int h, input int ph);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = W'(p);
        cfg_high   = W'(h);
        cfg_phase  = W'(ph);
    endtask

    task automatic set_en(input logic [3:0] v);
        en   = v;
        m_en = v;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; sync = 1'b0;
        cfg_period = '0; cfg_high = '0; cfg_phase = '0;
        en = 4'b0001; m_en = '0;

        // Reset holds every output low even with a channel enabled
        step("rst_hold", 4'b0, 4'b0, 4'b0);
        step("rst_hold", 4'b0, 4'b0, 4'b0);

        // Default period 2 after reset release
        rst = 1'b0;
        set_en(4'b0001);
        m_p[0] = 2; m_h[0] = 1; m_cnt[0] = 0;
        run("t1_def", 3, 4'b0);

        // Period 5 high 2, written mid-period so pending is visible
        write(0, 5, 2, 0);
        run("t2_wr", 1, 4'b0001);
        cfg_we = 1'b0;
        m_p[0] = 5; m_h[0] = 2;
        run("t2_p5", 10, 4'b0);

        // Period 10 -> 3 written at cnt=4: old period completes first
        set_en(4'b0000);
        write(0, 10, 5, 0);
        step("t3_idle", 4'b0, 4'b0, 4'b0);
        cfg_we = 1'b0;
        set_en(4'b0001);
        m_p[0] = 10; m_h[0] = 5; m_cnt[0] = 0;
        run("t3_old", 5, 4'b0);
        write(0, 3, 1, 0);
        run("t3_wr", 1, 4'b0001);
        cfg_we = 1'b0;
        run("t3_tail", 4, 4'b0001);
        m_p[0] = 3; m_h[0] = 1;
        run("t3_new", 6, 4'b0);

        // Clamps
        set_en(4'b0000);
        write(0, 0, 0, 0);
        step("t4_idle0", 4'b0, 4'b0, 4'b0);
        cfg_we = 1'b0;
        set_en(4'b0001);
        m_p[0] = 2; m_h[0] = 1; m_cnt[0] = 0;
        run("t4_min", 4, 4'b0);
        set_en(4'b0000);
        write(0, 4, 9, 7);
        step("t4_idle1", 4'b0, 4'b0, 4'b0);
        cfg_we = 1'b0;
        set_en(4'b0001);
        m_p[0] = 4; m_h[0] = 3; m_cnt[0] = 0;
        run("t4_clamp", 8, 4'b0);

        // Sync realignment, ch0 phase 0 and ch1 phase 2
        set_en(4'b0000);
        write(0, 4, 2, 0);
        step("t5_cfg0", 4'b0, 4'b0, 4'b0);
        write(1, 4, 2, 2);
        step("t5_cfg1", 4'b0, 4'b0, 4'b0);
        cfg_we = 1'b0;
        set_en(4'b0001);
        m_p[0] = 4; m_h[0] = 2; m_cnt[0] = 0;
        run("t5_a", 1, 4'b0);
        set_en(4'b0011);
        m_p[1] = 4; m_h[1] = 2; m_cnt[1] = 2;
        run("t5_b", 5, 4'b0);
        sync = 1'b1;
        m_cnt[0] = 0; m_cnt[1] = 2;
        run("t5_sync", 1, 4'b0);
        sync = 1'b0;
        run("t5_post", 3, 4'b0);
        sync = 1'b1;
        m_cnt[0] = 0; m_cnt[1] = 2;
        run("t5_wsync", 1, 4'b0);
        sync = 1'b0;
        run("t5_wpost", 4, 4'b0);

        // Async reset mid-high discards the pending shadow write
        write(0, 7, 3, 0);
        run("t6_wr", 1, 4'b0001);
        cfg_we = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_async.clk_out", clk_out, 4'b0);
        chk("t6_async.tick", tick, 4'b0);
        chk("t6_async.pending", cfg_pending, 4'b0);
        @(negedge clk_in);
        step("t6_hold", 4'b0, 4'b0, 4'b0);
        rst = 1'b0;
        set_en(4'b0011);
        m_p[0] = 2; m_h[0] = 1; m_cnt[0] = 0;
        m_p[1] = 2; m_h[1] = 1; m_cnt[1] = 0;
        run("t6_def", 4, 4'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
